// File: rtl/race_tick_scheduler.sv
// Race tick scheduler: game-speed clock-enable generator and race phase
// sequencer (idle, countdown, run, pause, crash recovery).
module race_tick_scheduler #(
    parameter int unsigned BASE_DIV    = 444444,
    parameter int unsigned STEP_DIV    = 44444,
    parameter int unsigned MAX_SPEED   = 7,
    parameter int unsigned CD_TICKS    = 112,
    parameter int unsigned CRASH_TICKS = 224
) (
    input  logic       clock_in,
    input  logic       reset_n,
    input  logic       start,
    input  logic       pause,
    input  logic       accel,
    input  logic       brake,
    input  logic       crash,
    output logic       tick_o,
    output logic [2:0] speed,
    output logic [1:0] countdown,
    output logic [2:0] state
);

    localparam int unsigned PH_MAX =
        (CD_TICKS > CRASH_TICKS) ? CD_TICKS : CRASH_TICKS;
    localparam int PW = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

    localparam logic [26:0]   BASE_P  = 27'(BASE_DIV);
    localparam logic [26:0]   STEP_P  = 27'(STEP_DIV);
    localparam logic [2:0]    SPD_MAX = 3'(MAX_SPEED);
    localparam logic [PW-1:0] CD_LAST = PW'(CD_TICKS - 1);
    localparam logic [PW-1:0] CR_LAST = PW'(CRASH_TICKS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CD    = 3'd1,
        S_RUN   = 3'd2,
        S_PAUSE = 3'd3,
        S_CRASH = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [26:0]   cnt_q, cnt_d;
    logic [26:0]   per_q, per_d;
    logic [26:0]   cnt_inc, run_per;
    logic [PW-1:0] phase_q, phase_d;
    logic [2:0]    speed_q, speed_d;
    logic [1:0]    cd_q, cd_d;
    logic          tick_q, tick_d;
    logic          wrap, cd_done, cr_done;

    assign wrap    = (cnt_q == per_q - 27'd1);
    assign cnt_inc = wrap ? '0 : cnt_q + 27'd1;
    assign run_per = BASE_P - 27'(speed_q) * STEP_P;
    assign cd_done = wrap && (phase_q == CD_LAST) && (cd_q == 2'd1);
    assign cr_done = wrap && (phase_q == CR_LAST);

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start)   state_d = S_CD;
            S_CD:    if (cd_done) state_d = S_RUN;
            S_RUN: begin
                if (crash)      state_d = S_CRASH;
                else if (pause) state_d = S_PAUSE;
            end
            S_PAUSE: if (pause)   state_d = S_RUN;
            S_CRASH: if (cr_done) state_d = S_RUN;
            default:              state_d = S_IDLE;
        endcase
    end

    // The counter only advances in cycles that stay in a counting state,
    // so a pause freezes it exactly where the pulse arrived.
    always_comb begin
        cnt_d   = cnt_q;
        per_d   = per_q;
        phase_d = phase_q;
        speed_d = speed_q;
        cd_d    = cd_q;
        tick_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    cnt_d   = '0;
                    phase_d = '0;
                    cd_d    = 2'd3;
                    per_d   = BASE_P;
                end
            end
            S_CD: begin
                cnt_d = cnt_inc;
                if (wrap) begin
                    if (phase_q == CD_LAST) begin
                        phase_d = '0;
                        cd_d    = cd_q - 2'd1;
                        if (cd_q == 2'd1) per_d = run_per;
                    end else begin
                        phase_d = phase_q + 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (crash) begin
                    speed_d = '0;
                    cnt_d   = '0;
                    phase_d = '0;
                    per_d   = BASE_P;
                end else if (!pause) begin
                    cnt_d = cnt_inc;
                    if (wrap) begin
                        per_d  = run_per;
                        tick_d = 1'b1;
                    end
                    unique case (1'b1)
                        accel && !brake && speed_q != SPD_MAX:
                            speed_d = speed_q + 3'd1;
                        brake && !accel && speed_q != 3'd0:
                            speed_d = speed_q - 3'd1;
                        default: ;
                    endcase
                end
            end
            S_PAUSE: ;
            S_CRASH: begin
                cnt_d = cnt_inc;
                if (wrap) begin
                    if (phase_q == CR_LAST) begin
                        phase_d = '0;
                        speed_d = '0;
                        per_d   = BASE_P;
                    end else begin
                        phase_d = phase_q + 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q   <= '0;
            per_q   <= '0;
            phase_q <= '0;
            speed_q <= '0;
            cd_q    <= '0;
            tick_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            per_q   <= per_d;
            phase_q <= phase_d;
            speed_q <= speed_d;
            cd_q    <= cd_d;
            tick_q  <= tick_d;
        end
    end

    assign tick_o    = tick_q;
    assign speed     = speed_q;
    assign countdown = cd_q;
    assign state     = state_q;

endmodule
